bucket_sch: RTL and testbench
=============================

Name: bucket_sch

Overview:
- Two-port frame scheduler sitting directly upstream of the token-bucket manager.
- Each port feeds it from a first-word-fall-through (FWFT) frame FIFO. It picks a port by round-robin and streams one whole frame to the shared output.
- At each start of frame (SOP) it reports the frame length to the bucket manager via bucket_inc_wr/bucket_inc_wdata.
- It stops starting new frames while bucket_af is high, and stamps each frame with its expected end-of-frame bucket count for the downstream credit check.

Parameters:
- DATA_W, 256, frame data width in bits (32 bytes per word).
- DATA_BWIDTH, 5, log2 of bytes per word.
- LEN_WIDTH, 11, frame byte-length width, carried in the SOP word data[LEN_WIDTH-1:0].
- DEPTH_WIDTH, 9, bucket count width.

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous, active-high.
- p0_ff_empty, in, 1, port0 FIFO empty.
- p0_ff_rd, out, 1, port0 pop; FWFT, so data is valid while not empty.
- p0_ff_rdata, in, DATA_W+2, {sop, eop, data}.
- p1_ff_empty / p1_ff_rd / p1_ff_rdata: same as port0, for port1.
- bucket_af, in, 1, bucket almost full; blocks new frames.
- bucket_inc_cnt, in, DEPTH_WIDTH, current cumulative bucket-increment count.
- bucket_inc_wr, out, 1, one-cycle pulse per frame.
- bucket_inc_wdata, out, LEN_WIDTH, frame byte length.
- out_rdy, in, 1, downstream can accept; deasserts with at least 2 words of slack remaining.
- out_vld, out, 1, output word valid.
- out_sop / out_eop, out, 1 each, frame delimiters.
- out_data, out, DATA_W, frame word.
- out_port, out, 1, source port of the current frame.
- out_tag, out, DEPTH_WIDTH, expected bucket count at end of this frame.
- sch_len_err, out, 1, pulse on length/word-count mismatch.

Behaviour:
- Reset values: all outputs 0, FSM = IDLE, round-robin pointer = port0.
- FSM IDLE:
  - A frame starts when bucket_af==0, out_rdy==1 and at least one port has empty==0 with sop==1 on its head word.
  - Port choice: the round-robin pointer port if eligible, else the other port.
  - Latch sel, go to SEND. No pop occurs in the IDLE cycle.
- FSM SEND:
  - pN_ff_rd = (sel==N) & ~pN_ff_empty & out_rdy.
  - Each popped word is registered to out_* one cycle later, with out_vld=1.
  - Popping the eop word returns the FSM to IDLE and sets the round-robin pointer to ~sel.
  - A stall (empty or ~out_rdy) inserts idle cycles with out_vld=0 and keeps the FSM in SEND.
- bucket_af is sampled only in IDLE. A frame already in SEND always completes, even if bucket_af rises mid-frame; the manager's MAX_FRM_CNT reserve covers this overshoot.
- At the SOP pop (cycle T):
  - len = data[LEN_WIDTH-1:0].
  - bucket_inc_wr=1 and bucket_inc_wdata=len in cycle T+1, as a single-cycle pulse.
  - units = len[LEN_WIDTH-1:DATA_BWIDTH] + (|len[DATA_BWIDTH-1:0]), i.e. ceil(len/32).
  - out_tag = bucket_inc_cnt(T) + units, modulo 2^DEPTH_WIDTH (wrap permitted). Registered with the SOP word and held constant until the next SOP.
- Word counting:
  - A word counter counts the popped words of the frame.
  - At the eop pop, if the count != units, or len==0, sch_len_err pulses for 1 cycle at T+1. The frame is still forwarded unchanged.
- Malformed input:
  - A head word with sop==0 while IDLE is popped and discarded, and sch_len_err pulses.
  - A word with sop==1 during SEND is treated as an implicit eop of the current frame plus an error pulse. That word is not popped; it becomes the next frame's SOP.
- Single-word frame (sop & eop on the same word): SEND lasts 1 cycle, and the FSM returns to IDLE in the next cycle.
- Throughput: back-to-back frames incur 1 IDLE bubble cycle between the eop pop and the next sop pop.
- Reset asserted mid-frame: everything clears immediately. Any partial frame is dropped from the output with no eop emitted; downstream must also be reset.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, SEND).
  - SOP/EOP bit positions in rdata.
  - The units (ceil-divide) function, shared with bucket_proc's increment logic.
- One sub-module, bucket_rr_arb: 2-request round-robin arbiter with pointer update on grant-done.

Test Plan:
- Single frame: port0 len=100 (4 words), af=0 → bucket_inc_wr pulse with wdata=100; 4 out words sop..eop; out_tag = inc_cnt+4; out_port=0.
- Fairness: both ports hold 3 frames of 64 bytes → output order p0,p1,p0,p1,p0,p1, with a 1-cycle bubble between frames.
- Bucket block: bucket_af=1 before SOP → no pops and no inc_wr; drop af → frame starts within 2 cycles. af rising mid-frame → frame completes with all words.
- Length mismatch: len=65 (3 units) sent as 2 words → sch_len_err pulses once at the eop+1 cycle; frame forwarded unchanged.
- Backpressure/empty: out_rdy toggles every cycle and the FIFO goes empty mid-frame → no word lost or duplicated, out_vld only on popped words.
- Wrap: inc_cnt=510, len=96 → out_tag=1; reset asserted mid-frame → all outputs 0 the same cycle, pointer back to port0.

Source files
------------

// File: rtl/bucket_sch_pkg.sv
// Shared definitions for the two-port frame scheduler: FSM encoding, FIFO word
// layout and the byte-length to bucket-unit conversion also used by bucket_proc.
package bucket_sch_pkg;

    localparam int PKG_LEN_W   = 11;
    localparam int PKG_BWIDTH  = 5;
    localparam int PKG_UNITS_W = PKG_LEN_W - PKG_BWIDTH + 1;

    // sop/eop sit directly above the data field: rdata = {sop, eop, data}
    localparam int SOP_OFS = 1;
    localparam int EOP_OFS = 0;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } sch_state_t;

    // ceil(len / bytes-per-word)
    function automatic logic [PKG_UNITS_W-1:0] calc_units(input logic [PKG_LEN_W-1:0] len);
        return PKG_UNITS_W'(len[PKG_LEN_W-1:PKG_BWIDTH]) + PKG_UNITS_W'(|len[PKG_BWIDTH-1:0]);
    endfunction

endpackage

// File: rtl/bucket_rr_arb.sv
// Two-request round-robin arbiter; the pointer moves past the served port
// only once its frame is finished.
module bucket_rr_arb
    import bucket_sch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       done,
    input  logic       done_sel,
    output logic       grant_sel,
    output logic       grant_vld
);

    logic ptr_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg <= 1'b0;
        end else if (done) begin
            ptr_reg <= ~done_sel;
        end
    end

    always_comb begin
        grant_sel = req[ptr_reg] ? ptr_reg : ~ptr_reg;
        grant_vld = |req;
    end

endmodule

// File: rtl/bucket_sch.sv
// Two-port frame scheduler: round-robin whole-frame forwarding, bucket increment
// reporting at SOP and end-of-frame bucket tag stamping.
module bucket_sch
    import bucket_sch_pkg::*;
#(
    parameter int DATA_W      = 256,
    parameter int DATA_BWIDTH = 5,
    parameter int LEN_WIDTH   = 11,
    parameter int DEPTH_WIDTH = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   p0_ff_empty,
    output logic                   p0_ff_rd,
    input  logic [DATA_W+1:0]      p0_ff_rdata,
    input  logic                   p1_ff_empty,
    output logic                   p1_ff_rd,
    input  logic [DATA_W+1:0]      p1_ff_rdata,
    input  logic                   bucket_af,
    input  logic [DEPTH_WIDTH-1:0] bucket_inc_cnt,
    output logic                   bucket_inc_wr,
    output logic [LEN_WIDTH-1:0]   bucket_inc_wdata,
    input  logic                   out_rdy,
    output logic                   out_vld,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_port,
    output logic [DEPTH_WIDTH-1:0] out_tag,
    output logic                   sch_len_err
);

    localparam int UNITS_W = LEN_WIDTH - DATA_BWIDTH + 1;

    sch_state_t           state_reg, state_next;
    logic                 sel_reg, sel_next;
    logic [LEN_WIDTH-1:0] len_reg;
    logic [LEN_WIDTH-1:0] word_cnt_reg;

    logic [1:0]           ff_empty, head_sop, head_eop, ff_rd;
    logic                 h_empty, h_sop, h_eop;
    logic [DATA_W-1:0]    sel_data;
    logic [LEN_WIDTH-1:0] head_len, cur_len, cnt_now;
    logic [UNITS_W-1:0]   head_units, cur_units;
    logic                 pop, sop_pop, done, err_next;
    logic                 arb_sel, arb_vld;

    assign ff_empty = {p1_ff_empty, p0_ff_empty};
    assign head_sop = {p1_ff_rdata[DATA_W+SOP_OFS], p0_ff_rdata[DATA_W+SOP_OFS]};
    assign head_eop = {p1_ff_rdata[DATA_W+EOP_OFS], p0_ff_rdata[DATA_W+EOP_OFS]};

    assign h_empty  = ff_empty[sel_reg];
    assign h_sop    = head_sop[sel_reg];
    assign h_eop    = head_eop[sel_reg];
    assign sel_data = sel_reg ? p1_ff_rdata[DATA_W-1:0] : p0_ff_rdata[DATA_W-1:0];
    assign head_len = sel_data[LEN_WIDTH-1:0];

    // A head word carrying sop is always the first word of its frame, so the
    // length source and word count restart whenever it is the one being popped.
    assign cur_len    = h_sop ? head_len : len_reg;
    assign head_units = UNITS_W'(calc_units(head_len));
    assign cur_units  = UNITS_W'(calc_units(cur_len));
    assign cnt_now    = h_sop ? LEN_WIDTH'(1) :
                        (&word_cnt_reg) ? word_cnt_reg : word_cnt_reg + 1'b1;

    bucket_rr_arb u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (~ff_empty & head_sop),
        .done      (done),
        .done_sel  (sel_reg),
        .grant_sel (arb_sel),
        .grant_vld (arb_vld)
    );

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        ff_rd      = 2'b00;
        pop        = 1'b0;
        sop_pop    = 1'b0;
        done       = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                // heads without sop cannot start a frame; drop them
                ff_rd    = ~ff_empty & ~head_sop;
                err_next = |ff_rd;
                if (!bucket_af && out_rdy && arb_vld) begin
                    state_next = SEND;
                    sel_next   = arb_sel;
                end
            end
            SEND: begin
                if (!h_empty && h_sop && (word_cnt_reg != '0)) begin
                    // new sop mid-frame: close the current frame, leave the word queued
                    done       = 1'b1;
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else if (!h_empty && out_rdy) begin
                    pop            = 1'b1;
                    sop_pop        = h_sop;
                    ff_rd[sel_reg] = 1'b1;
                    if (h_eop) begin
                        done       = 1'b1;
                        state_next = IDLE;
                        err_next   = (cnt_now != LEN_WIDTH'(cur_units)) || (cur_len == '0);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign p0_ff_rd = ff_rd[0] & ~reset;
    assign p1_ff_rd = ff_rd[1] & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            sel_reg          <= 1'b0;
            len_reg          <= '0;
            word_cnt_reg     <= '0;
            out_vld          <= 1'b0;
            out_sop          <= 1'b0;
            out_eop          <= 1'b0;
            out_data         <= '0;
            out_port         <= 1'b0;
            out_tag          <= '0;
            bucket_inc_wr    <= 1'b0;
            bucket_inc_wdata <= '0;
            sch_len_err      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sel_reg       <= sel_next;
            out_vld       <= pop;
            out_sop       <= pop & h_sop;
            out_eop       <= pop & h_eop;
            bucket_inc_wr <= sop_pop;
            sch_len_err   <= err_next;
            if (pop) begin
                out_data <= sel_data;
                out_port <= sel_reg;
            end
            if (sop_pop) begin
                len_reg          <= head_len;
                bucket_inc_wdata <= head_len;
                out_tag          <= bucket_inc_cnt + DEPTH_WIDTH'(head_units);
            end
            if (done) begin
                word_cnt_reg <= '0;
            end else if (pop) begin
                word_cnt_reg <= cnt_now;
            end
        end
    end

endmodule

// File: tb/tb_bucket_sch.sv
// Scoreboard bench for bucket_sch: FWFT FIFO models per port, expected output
// words and bucket increments queued at stimulus time and compared as they emerge.
module tb_bucket_sch;

    localparam int DW  = 256;
    localparam int LW  = 11;
    localparam int DPW = 9;

    typedef logic [DW+1:0] word_t;
    typedef struct packed {
        logic           sop;
        logic           eop;
        logic [DW-1:0]  data;
        logic           port;
        logic [DPW-1:0] tag;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           p0_ff_empty, p0_ff_rd, p1_ff_empty, p1_ff_rd;
    logic [DW+1:0]  p0_ff_rdata, p1_ff_rdata;
    logic           bucket_af = 1'b0;
    logic [DPW-1:0] bucket_inc_cnt = '0;
    logic           bucket_inc_wr;
    logic [LW-1:0]  bucket_inc_wdata;
    logic           out_rdy = 1'b1;
    logic           out_vld, out_sop, out_eop, out_port, sch_len_err;
    logic [DW-1:0]  out_data;
    logic [DPW-1:0] out_tag;

    word_t          q0[$], q1[$];
    exp_t           exp_q[$];
    logic [LW-1:0]  exp_inc[$];
    int             gap_q[$];
    int             tests = 0, fails = 0, cyc = 0, err_cnt = 0, err_eop = 0, last_eop = 0;
    logic           prev_pop = 1'b0, in_frame = 1'b0, hold0 = 1'b0, hold1 = 1'b0;
    logic [DPW-1:0] last_tag = '0;

    always #5 clk = ~clk;

    bucket_sch dut (
        .clk              (clk),
        .reset            (reset),
        .p0_ff_empty      (p0_ff_empty),
        .p0_ff_rd         (p0_ff_rd),
        .p0_ff_rdata      (p0_ff_rdata),
        .p1_ff_empty      (p1_ff_empty),
        .p1_ff_rd         (p1_ff_rd),
        .p1_ff_rdata      (p1_ff_rdata),
        .bucket_af        (bucket_af),
        .bucket_inc_cnt   (bucket_inc_cnt),
        .bucket_inc_wr    (bucket_inc_wr),
        .bucket_inc_wdata (bucket_inc_wdata),
        .out_rdy          (out_rdy),
        .out_vld          (out_vld),
        .out_sop          (out_sop),
        .out_eop          (out_eop),
        .out_data         (out_data),
        .out_port         (out_port),
        .out_tag          (out_tag),
        .sch_len_err      (sch_len_err)
    );

    function automatic void refresh();
        p0_ff_empty = (q0.size() == 0) || hold0;
        p0_ff_rdata = (q0.size() != 0) ? q0[0] : '0;
        p1_ff_empty = (q1.size() == 0) || hold1;
        p1_ff_rdata = (q1.size() != 0) ? q1[0] : '0;
    endfunction

    function automatic word_t mk_word(input int seed, input int idx, input int len,
                                      input logic sop, input logic eop);
        logic [DW-1:0] d;
        d = {8{seed[15:0], idx[15:0]}};
        if (sop) d[LW-1:0] = LW'(len);
        return {sop, eop, d};
    endfunction

    task automatic feed(input logic port, input int len, input int nw, input int seed);
        for (int i = 0; i < nw; i++) begin
            if (port) q1.push_back(mk_word(seed, i, len, i == 0, i == nw - 1));
            else      q0.push_back(mk_word(seed, i, len, i == 0, i == nw - 1));
        end
        refresh();
    endtask

    task automatic expect_frm(input logic port, input int len, input int nw, input int seed);
        word_t          w;
        logic [DPW-1:0] tag;
        tag = bucket_inc_cnt + DPW'((len + 31) / 32);
        for (int i = 0; i < nw; i++) begin
            w = mk_word(seed, i, len, i == 0, i == nw - 1);
            exp_q.push_back({w[DW+1], w[DW], w[DW-1:0], port, tag});
        end
        exp_inc.push_back(LW'(len));
    endtask

    // One clock: compare what the DUT shows, then retire the FIFO words it popped.
    task automatic tick();
        logic  r0, r1, pop0, pop1, vexp;
        word_t w;
        exp_t  e;
        @(negedge clk);
        cyc++;
        tests++;
        if (out_vld !== prev_pop) begin
            fails++;
            $display("FAIL out_vld cycle %0d: got %b want %b", cyc, out_vld, prev_pop);
        end
        if (out_vld === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_word cycle %0d: got data[31:0]=%h, want none", cyc, out_data[31:0]);
            end else begin
                e = exp_q.pop_front();
                if ({out_sop, out_eop, out_data, out_port, out_tag} !== e)
                begin
                    fails++;
                    $display("FAIL out_word cycle %0d: got sop=%b eop=%b port=%b tag=%0d d=%h, want sop=%b eop=%b port=%b tag=%0d d=%h",
                             cyc, out_sop, out_eop, out_port, out_tag, out_data[31:0],
                             e.sop, e.eop, e.port, e.tag, e.data[31:0]);
                end
            end
            if (out_sop === 1'b1) begin
                if (last_eop != 0) gap_q.push_back(cyc - last_eop);
                last_tag = out_tag;
            end
            if (out_eop === 1'b1) last_eop = cyc;
        end
        if (bucket_inc_wr === 1'b1) begin
            tests++;
            if (exp_inc.size() == 0) begin
                fails++;
                $display("FAIL unexpected_inc cycle %0d: got wdata=%0d, want no pulse", cyc, bucket_inc_wdata);
            end else if (bucket_inc_wdata !== exp_inc[0]) begin
                fails++;
                $display("FAIL inc_wdata cycle %0d: got %0d want %0d", cyc, bucket_inc_wdata, exp_inc[0]);
                void'(exp_inc.pop_front());
            end else begin
                void'(exp_inc.pop_front());
            end
        end
        if (sch_len_err === 1'b1) begin
            err_cnt++;
            if (out_vld === 1'b1 && out_eop === 1'b1) err_eop++;
        end
        r0 = p0_ff_rd;
        r1 = p1_ff_rd;
        tests++;
        if ((r0 && p0_ff_empty) || (r1 && p1_ff_empty)) begin
            fails++;
            $display("FAIL rd_while_empty cycle %0d: got rd=%b%b empty=%b%b, want no rd on empty",
                     cyc, r1, r0, p1_ff_empty, p0_ff_empty);
        end
        pop0 = r0 && !p0_ff_empty;
        pop1 = r1 && !p1_ff_empty;
        vexp = 1'b0;
        @(posedge clk);
        #1;
        if (pop0 || pop1) begin
            w = pop0 ? q0.pop_front() : q1.pop_front();
            if (pop0 && pop1) void'(q1.pop_front());
            vexp = w[DW+1] | in_frame;
            if (w[DW+1])   in_frame = ~w[DW];
            else if (w[DW]) in_frame = 1'b0;
        end
        prev_pop = vexp;
        refresh();
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_inc.size() != 0) && n < max_cyc) begin
            tick();
            n++;
        end
        tests++;
        if (exp_q.size() != 0 || exp_inc.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d words %0d incs pending, want 0", exp_q.size(), exp_inc.size());
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        refresh();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({out_vld, out_sop, out_eop, out_data, out_port, out_tag, bucket_inc_wr,
             bucket_inc_wdata, sch_len_err, p0_ff_rd, p1_ff_rd} !== '0) begin
            fails++;
            $display("FAIL reset_values: got vld=%b tag=%0d inc_wr=%b err=%b, want all 0",
                     out_vld, out_tag, bucket_inc_wr, sch_len_err);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_frame();
        int e0;
        e0 = err_cnt;
        bucket_inc_cnt = 9'd20;
        feed(1'b0, 100, 4, 10);
        expect_frm(1'b0, 100, 4, 10);
        drain(40);
        tests++;
        if (err_cnt != e0) begin
            fails++;
            $display("FAIL single_err: got %0d pulses want 0", err_cnt - e0);
        end
        tests++;
        if (last_tag !== 9'd24) begin
            fails++;
            $display("FAIL single_tag: got %0d want 24", last_tag);
        end
    endtask

    task automatic test_len_mismatch();
        int e0, ee0;
        e0 = err_cnt;
        ee0 = err_eop;
        feed(1'b1, 65, 2, 20);
        expect_frm(1'b1, 65, 2, 20);
        drain(40);
        tests++;
        if (err_cnt - e0 != 1 || err_eop - ee0 != 1) begin
            fails++;
            $display("FAIL len_mismatch_err: got %0d pulses (%0d with eop), want 1 (1)", err_cnt - e0, err_eop - ee0);
        end
    endtask

    task automatic test_fairness();
        for (int i = 0; i < 3; i++) begin
            feed(1'b0, 64, 2, 30 + i);
            feed(1'b1, 64, 2, 40 + i);
        end
        for (int i = 0; i < 3; i++) begin
            expect_frm(1'b0, 64, 2, 30 + i);
            expect_frm(1'b1, 64, 2, 40 + i);
        end
        gap_q.delete();
        last_eop = 0;
        drain(80);
        tests++;
        if (gap_q.size() != 5) begin
            fails++;
            $display("FAIL fair_gap_count: got %0d want 5", gap_q.size());
        end
        foreach (gap_q[i]) begin
            tests++;
            if (gap_q[i] != 2) begin
                fails++;
                $display("FAIL fair_bubble[%0d]: got eop-to-sop %0d cycles want 2", i, gap_q[i]);
            end
        end
    endtask

    task automatic test_bucket_block();
        bucket_af = 1'b1;
        feed(1'b0, 64, 2, 50);
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (p0_ff_rd !== 1'b0 || bucket_inc_wr !== 1'b0 || q0.size() != 2) begin
                fails++;
                $display("FAIL af_block: got rd=%b inc_wr=%b fifo=%0d, want 0 0 2", p0_ff_rd, bucket_inc_wr, q0.size());
            end
        end
        expect_frm(1'b0, 64, 2, 50);
        bucket_af = 1'b0;
        tick();
        tick();
        tests++;
        if (q0.size() != 1) begin
            fails++;
            $display("FAIL af_release: got fifo=%0d after 2 cycles want 1", q0.size());
        end
        drain(40);
        feed(1'b0, 128, 4, 51);
        expect_frm(1'b0, 128, 4, 51);
        for (int i = 0; i < 10 && q0.size() > 3; i++) tick();
        bucket_af = 1'b1;
        feed(1'b0, 64, 2, 52);
        expect_frm(1'b0, 64, 2, 52);
        for (int i = 0; i < 12; i++) tick();
        tests++;
        if (exp_q.size() != 2 || q0.size() != 2) begin
            fails++;
            $display("FAIL af_midframe: got pending=%0d fifo=%0d want 2 2", exp_q.size(), q0.size());
        end
        bucket_af = 1'b0;
        drain(40);
    endtask

    task automatic test_backpressure();
        feed(1'b1, 200, 7, 60);
        expect_frm(1'b1, 200, 7, 60);
        feed(1'b1, 40, 2, 61);
        expect_frm(1'b1, 40, 2, 61);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            out_rdy = i[0];
            hold1 = (i >= 5 && i < 9);
            refresh();
            tick();
        end
        out_rdy = 1'b1;
        hold1 = 1'b0;
        refresh();
        drain(40);
    endtask

    task automatic test_malformed();
        int    e0;
        word_t w;
        e0 = err_cnt;
        q0.push_back(mk_word(70, 1, 0, 1'b0, 1'b0));
        refresh();
        for (int i = 0; i < 3; i++) tick();
        tests++;
        if (q0.size() != 0 || err_cnt - e0 != 1) begin
            fails++;
            $display("FAIL garbage_drop: got fifo=%0d err=%0d want 0 1", q0.size(), err_cnt - e0);
        end
        e0 = err_cnt;
        q0.push_back(mk_word(71, 0, 64, 1'b1, 1'b0));
        q0.push_back(mk_word(72, 0, 32, 1'b1, 1'b1));
        refresh();
        w = mk_word(71, 0, 64, 1'b1, 1'b0);
        exp_q.push_back({w[DW+1], w[DW], w[DW-1:0], 1'b0, bucket_inc_cnt + 9'd2});
        exp_inc.push_back(11'd64);
        w = mk_word(72, 0, 32, 1'b1, 1'b1);
        exp_q.push_back({w[DW+1], w[DW], w[DW-1:0], 1'b0, bucket_inc_cnt + 9'd1});
        exp_inc.push_back(11'd32);
        drain(40);
        tests++;
        if (err_cnt - e0 != 1) begin
            fails++;
            $display("FAIL implicit_eop_err: got %0d pulses want 1", err_cnt - e0);
        end
    endtask

    task automatic test_wrap();
        bucket_inc_cnt = 9'd510;
        feed(1'b1, 96, 3, 80);
        expect_frm(1'b1, 96, 3, 80);
        drain(40);
        tests++;
        if (last_tag !== 9'd1) begin
            fails++;
            $display("FAIL wrap_tag: got %0d want 1", last_tag);
        end
    endtask

    task automatic test_reset_mid();
        bucket_inc_cnt = 9'd40;
        feed(1'b0, 64, 2, 90);
        expect_frm(1'b0, 64, 2, 90);
        drain(40);
        feed(1'b1, 256, 8, 91);
        expect_frm(1'b1, 256, 8, 91);
        for (int i = 0; i < 40 && exp_q.size() > 5; i++) tick();
        tests++;
        if (exp_q.size() != 5) begin
            fails++;
            $display("FAIL reset_mid_progress: got %0d pending want 5", exp_q.size());
        end
        reset = 1'b1;
        prev_pop = 1'b0;
        in_frame = 1'b0;
        q0.delete();
        q1.delete();
        exp_q.delete();
        exp_inc.delete();
        refresh();
        #1;
        tests++;
        if ({out_vld, out_sop, out_eop, out_data, out_port, out_tag, bucket_inc_wr,
             bucket_inc_wdata, sch_len_err, p0_ff_rd, p1_ff_rd} !== '0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got vld=%b tag=%0d data=%h, want all 0", out_vld, out_tag, out_data[31:0]);
        end
        tick();
        tick();
        reset = 1'b0;
        last_eop = 0;
        feed(1'b1, 32, 1, 92);
        feed(1'b0, 32, 1, 93);
        expect_frm(1'b0, 32, 1, 93);
        expect_frm(1'b1, 32, 1, 92);
        drain(40);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_len_mismatch();
        test_fairness();
        test_bucket_block();
        test_backpressure();
        test_malformed();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
